// File: rtl/subword_store_rmw.sv
// Sub-word store engine: turns byte/halfword stores into a read-modify-write
// of the containing 32-bit word; word stores are written directly.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   req              store request, sampled only while idle
//   size             00 byte, 01 halfword, 10 word, 11 reserved
//   addr             byte address of the store
//   wdata            register value; only the low 8/16/32 bits are stored
//   busy             high whenever an operation is in flight
//   done             one-cycle pulse in the write cycle
//   err              one-cycle pulse for a rejected request
//   mem_addr         word-aligned memory address (holds between accesses)
//   mem_re           memory read strobe
//   mem_rdata        memory read data, valid the cycle after mem_re
//   mem_we           memory write strobe
//   mem_wdata        merged word to write (holds between accesses)

module subword_store_rmw #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        ERR
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              accept;
    logic              misaligned;
    logic [1:0]        lane_q;
    logic              half_q;
    logic [15:0]       data_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       merged;

    assign accept = (state == IDLE) && req;

    // Reserved size is treated as a misaligned request.
    always_comb begin
        misaligned = 1'b0;
        unique case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = addr[0];
            SZ_WORD: misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (misaligned) begin
                        state_nxt = ERR;
                    end else if (size == SZ_WORD) begin
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            READ:  state_nxt = WAIT;
            WAIT:  state_nxt = WRITE;
            WRITE: state_nxt = IDLE;
            ERR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes decode straight from the state register so that an
    // asynchronous reset drops them without waiting for a clock edge.
    always_comb begin
        busy   = 1'b1;
        mem_re = 1'b0;
        mem_we = 1'b0;
        done   = 1'b0;
        err    = 1'b0;
        unique case (state)
            IDLE:  busy = 1'b0;
            READ:  mem_re = 1'b1;
            WAIT:  busy = 1'b1;
            WRITE: begin
                mem_we = 1'b1;
                done   = 1'b1;
            end
            ERR:   err = 1'b1;
            default: busy = 1'b1;
        endcase
    end

    // Insert the stored byte/halfword into the word read from memory.
    always_comb begin
        merged = mem_rdata;
        if (half_q) begin
            merged[{lane_q[1], 4'b0000} +: 16] = data_q;
        end else begin
            merged[{lane_q, 3'b000} +: 8] = data_q[7:0];
        end
    end

    // Request latch and memory-side registers. mem_addr/mem_wdata only
    // move when a memory access is about to happen, so a rejected request
    // leaves them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q      <= 2'b00;
            half_q      <= 1'b0;
            data_q      <= 16'h0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0000_0000;
        end else begin
            if (accept) begin
                lane_q <= addr[1:0];
                half_q <= (size == SZ_HALF);
                data_q <= wdata[15:0];
                if (!misaligned) begin
                    mem_addr_q <= {addr[ADDR_W-1:2], 2'b00};
                    if (size == SZ_WORD) begin
                        mem_wdata_q <= wdata;
                    end
                end
            end
            if (state == WAIT) begin
                mem_wdata_q <= merged;
            end
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
